// File: rtl/error_injection_sequencer_if.sv
// Command and injection-bus bundle of the error-injection sequencer.
// master = host/parser + routers, slave = sequencer.
interface error_injection_sequencer_if #(
   parameter int ID_W = 16
);
   logic            cmd_valid;
   logic            cmd_ready;
   logic [ID_W-1:0] cmd_id;
   logic [1:0]      cmd_mode;
   logic [15:0]     cmd_count;
   logic [15:0]     cmd_gap;
   logic            trig;
   logic            abort;
   logic            err_en;
   logic [ID_W-1:0] err_ctrl;
   logic            busy;
   logic            done;
   logic [15:0]     inj_cnt;

   modport master (
      output cmd_valid, cmd_id, cmd_mode, cmd_count, cmd_gap,
      output trig, abort,
      input  cmd_ready, err_en, err_ctrl, busy, done, inj_cnt
   );

   modport slave (
      input  cmd_valid, cmd_id, cmd_mode, cmd_count, cmd_gap,
      input  trig, abort,
      output cmd_ready, err_en, err_ctrl, busy, done, inj_cnt
   );
endinterface

// File: rtl/error_injection_sequencer.sv
// Error-injection sequencer: turns one host command into timed
// err_en/err_ctrl pulses on the bus shared by all region routers.
module error_injection_sequencer #(
   parameter int              ID_W    = 16,
   parameter logic [ID_W-1:0] IDLE_ID = 16'hFFFF,
   parameter int              JIT_W   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   error_injection_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_WAIT,
      S_FIRE,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] id_q;
   logic [ID_W-1:0] ctrl_q, ctrl_d;
   logic [1:0]      mode_q;
   logic [15:0]     count_q;
   logic [15:0]     gap_q;
   logic [15:0]     cnt_q, cnt_d;
   logic [15:0]     inj_q, inj_d;
   logic [15:0]     lfsr_q;
   logic            en_q, en_d;
   logic            done_q, done_d;
   logic            accept;
   logic            jitter;
   logic            sweep;
   logic            last;
   logic            back2back;
   logic [16:0]     jit_sum;
   logic [15:0]     load_val;
   logic            fb;

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.err_en    = en_q;
   assign bus.err_ctrl  = ctrl_q;
   assign bus.done      = done_q;
   assign bus.inj_cnt   = inj_q;

   // abort in IDLE blocks a same-cycle accept
   assign accept = bus.cmd_valid & bus.cmd_ready
                 & ~bus.abort;

   assign jitter = (mode_q == 2'd3);
   assign sweep  = (mode_q == 2'd2);
   assign last   = (inj_q == count_q);

   // WAIT spends counter+1 cycles low; repeat pulses in modes
   // 0-2 reload gap-1 so they sit exactly gap cycles apart, and
   // gap 0 fires back to back without passing through WAIT.
   assign back2back = !jitter && (gap_q == 16'd0);

   // 17-bit add so a large gap plus jitter clamps instead of wrapping
   assign jit_sum = {1'b0, gap_q}
                  + 17'(lfsr_q[JIT_W-1:0]);

   assign load_val = !jitter     ? gap_q :
                     jit_sum[16] ? 16'hFFFF :
                                   jit_sum[15:0];

   assign fb = lfsr_q[15] ^ lfsr_q[13]
             ^ lfsr_q[12] ^ lfsr_q[10];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode; abort wins in every busy state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (bus.abort)     state_d = S_IDLE;
            else if (bus.trig) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.abort)           state_d = S_IDLE;
            else if (cnt_q == 16'd0) state_d = S_FIRE;
         end
         S_FIRE: begin
            if (bus.abort)      state_d = S_IDLE;
            else if (last)      state_d = S_DONE;
            else if (back2back) state_d = S_FIRE;
            else                state_d = S_WAIT;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Next values of the registered outputs and gap counter
   always_comb begin
      en_d   = (state_d == S_FIRE);
      done_d = (state_d == S_DONE);

      inj_d = inj_q;
      if (accept)
         inj_d = '0;
      else if (state_d == S_FIRE)
         inj_d = inj_q + 16'd1;

      ctrl_d = ctrl_q;
      if (accept)
         ctrl_d = bus.cmd_id;
      else if (state_d == S_IDLE || state_d == S_DONE)
         ctrl_d = IDLE_ID;
      else if (sweep && state_q == S_FIRE)
         ctrl_d = (ctrl_q == '1) ? id_q
                                 : ctrl_q + ID_W'(1);

      cnt_d = cnt_q;
      unique case (1'b1)
         (state_q == S_ARMED && state_d == S_WAIT):
            cnt_d = load_val;
         (state_q == S_FIRE && state_d == S_WAIT):
            cnt_d = jitter ? load_val : gap_q - 16'd1;
         (state_q == S_WAIT && state_d == S_WAIT):
            cnt_d = cnt_q - 16'd1;
         default: ;
      endcase
   end

   // Command fields captured at accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_q    <= IDLE_ID;
         mode_q  <= 2'd0;
         count_q <= 16'd1;
         gap_q   <= 16'd0;
      end else if (accept) begin
         id_q    <= bus.cmd_id;
         mode_q  <= bus.cmd_mode;
         count_q <= (bus.cmd_mode == 2'd0 ||
                     bus.cmd_count == 16'd0)
                  ? 16'd1 : bus.cmd_count;
         gap_q   <= bus.cmd_gap;
      end
   end

   // Registered outputs and gap counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q   <= 1'b0;
         done_q <= 1'b0;
         ctrl_q <= IDLE_ID;
         inj_q  <= 16'd0;
         cnt_q  <= 16'd0;
      end else begin
         en_q   <= en_d;
         done_q <= done_d;
         ctrl_q <= ctrl_d;
         inj_q  <= inj_d;
         cnt_q  <= cnt_d;
      end
   end

   // Free-running jitter source, seeded nonzero so it never locks up
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= 16'h0001;
      else        lfsr_q <= {lfsr_q[14:0], fb};
   end

endmodule

// File: tb/tb_error_injection_sequencer.sv
// Bench for error_injection_sequencer: pulse-schedule model,
// directed scenarios and randomized commands.
module tb_error_injection_sequencer;

   localparam logic [15:0] IDLE = 16'hFFFF;

   localparam int P_IDLE  = 0;
   localparam int P_ARMED = 1;
   localparam int P_RUN   = 2;
   localparam int P_LAST  = 3;
   localparam int P_DONE  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic started = 1'b0;

   always #5 clk = ~clk;

   error_injection_sequencer_if #(.ID_W(16)) bus ();

   error_injection_sequencer #(
      .ID_W(16),
      .IDLE_ID(16'hFFFF),
      .JIT_W(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // model state: absolute pulse schedule
   int          ph = P_IDLE;
   logic [15:0] m_lfsr = 16'h0001;
   logic [15:0] lf_pre;
   logic [15:0] m_id, m_cur, m_gap;
   logic [1:0]  m_mode;
   int          m_target;
   int          next_pulse;
   logic        bump = 1'b0;
   logic        e_en = 1'b0;
   logic        e_done = 1'b0;
   logic [15:0] e_ctrl = 16'hFFFF;
   logic [15:0] e_inj = 16'd0;

   // observed pulses
   int          pq[$];
   logic [15:0] cq[$];
   int          ndone = 0;
   int          done_cyc = -1;

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic int jit_load(input logic [15:0] g,
                                   input logic [15:0] l);
      int s;
      s = int'(g) + int'(l[3:0]);
      return (s > 65535) ? 65535 : s;
   endfunction

   function automatic int first_wait(input logic [15:0] l);
      return (m_mode == 2'd3) ? jit_load(m_gap, l) : int'(m_gap);
   endfunction

   function automatic int low_run(input logic [15:0] l);
      return (m_mode == 2'd3) ? jit_load(m_gap, l) + 1 : int'(m_gap);
   endfunction

   task automatic chk(input string name, input longint act,
                      input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)",
                  name, act, act, exp, exp);
      end
   endtask

   // reference model, advanced on every clock edge out of reset
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         ph = P_IDLE; m_lfsr = 16'h0001; bump = 1'b0;
         e_en = 1'b0; e_done = 1'b0; e_ctrl = IDLE; e_inj = 16'd0;
      end else begin
         lf_pre = m_lfsr;
         m_lfsr = lfsr_next(m_lfsr);
         cyc++;
         e_en = 1'b0;
         e_done = 1'b0;
         if (ph != P_IDLE && bus.abort) begin
            ph = P_IDLE;
            e_ctrl = IDLE;
         end else begin
            case (ph)
               P_IDLE: if (bus.cmd_valid && !bus.abort) begin
                  m_id = bus.cmd_id; m_cur = bus.cmd_id;
                  m_mode = bus.cmd_mode; m_gap = bus.cmd_gap;
                  m_target = (bus.cmd_mode == 2'd0 || bus.cmd_count == 16'd0)
                           ? 1 : int'(bus.cmd_count);
                  e_ctrl = bus.cmd_id; e_inj = 16'd0; bump = 1'b0;
                  ph = P_ARMED;
               end
               P_ARMED: if (bus.trig) begin
                  next_pulse = cyc + 1 + first_wait(lf_pre);
                  ph = P_RUN;
               end
               P_RUN: begin
                  if (bump) begin
                     m_cur = (m_cur == 16'hFFFF) ? m_id : m_cur + 16'd1;
                     e_ctrl = m_cur;
                     bump = 1'b0;
                  end
                  if (cyc == next_pulse) begin
                     e_en = 1'b1;
                     e_inj = e_inj + 16'd1;
                     if (int'(e_inj) == m_target) ph = P_LAST;
                     else begin
                        next_pulse = cyc + 1 + low_run(m_lfsr);
                        bump = (m_mode == 2'd2);
                     end
                  end
               end
               P_LAST: begin
                  e_done = 1'b1;
                  e_ctrl = IDLE;
                  ph = P_DONE;
               end
               default: ph = P_IDLE;
            endcase
         end
      end
   end

   // per-cycle comparison and pulse monitor
   initial forever begin
      @(negedge clk);
      if (rst_n && started) begin
         tests++;
         if ({bus.err_en, bus.err_ctrl, bus.done, bus.inj_cnt,
              bus.cmd_ready, bus.busy} !==
             {e_en, e_ctrl, e_done, e_inj,
              ph == P_IDLE, ph != P_IDLE}) begin
            fails++;
            $display("FAIL cycle %0d: en=%b ctrl=%h done=%b inj=%0d rdy=%b busy=%b, required en=%b ctrl=%h done=%b inj=%0d rdy=%b busy=%b",
                     cyc, bus.err_en, bus.err_ctrl, bus.done, bus.inj_cnt,
                     bus.cmd_ready, bus.busy, e_en, e_ctrl, e_done, e_inj,
                     ph == P_IDLE, ph != P_IDLE);
         end
         if (bus.err_en) begin
            pq.push_back(cyc);
            cq.push_back(bus.err_ctrl);
         end
         if (bus.done) begin
            ndone++;
            done_cyc = cyc;
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bus.cmd_valid = 1'b0;
      bus.trig = 1'b0;
      bus.abort = 1'b0;
   endtask

   task automatic clear_mon();
      pq.delete();
      cq.delete();
      ndone = 0;
      done_cyc = -1;
   endtask

   task automatic send_cmd(input logic [15:0] id, input logic [1:0] mode,
                           input logic [15:0] count, input logic [15:0] gap);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_id = id;
      bus.cmd_mode = mode;
      bus.cmd_count = count;
      bus.cmd_gap = gap;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic do_trig(output int t);
      t = cyc;
      bus.trig = 1'b1;
      @(negedge clk);
      bus.trig = 1'b0;
   endtask

   task automatic wait_idle(input int maxc, input string name);
      int k;
      k = 0;
      while (!bus.cmd_ready && k < maxc) begin
         @(negedge clk);
         k++;
      end
      chk(name, bus.cmd_ready, 1);
   endtask

   initial begin
      int t;
      int k;
      logic [15:0] sw_exp [5];
      logic [15:0] rid, rcnt, rgap;
      logic [1:0]  rmode;

      idle_inputs();
      bus.cmd_id = 16'd0;
      bus.cmd_mode = 2'd0;
      bus.cmd_count = 16'd0;
      bus.cmd_gap = 16'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      started = 1'b1;
      @(negedge clk);

      // pin the model helpers
      chk("lfsr_seed_step", lfsr_next(16'h0001), 16'h0002);
      chk("lfsr_msb_feedback", lfsr_next(16'h8000), 16'h0001);
      chk("lfsr_all_taps", lfsr_next(16'hB400), 16'h6800);
      chk("jit_saturate", jit_load(16'hFFFE, 16'h000F), 65535);
      chk("jit_add", jit_load(16'd1, 16'h0005), 6);

      // reset state
      chk("rst_err_en", bus.err_en, 0);
      chk("rst_err_ctrl", bus.err_ctrl, 16'hFFFF);
      chk("rst_done", bus.done, 0);
      chk("rst_inj_cnt", bus.inj_cnt, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_busy", bus.busy, 0);

      // single
      clear_mon();
      send_cmd(16'd5, 2'd0, 16'd7, 16'd3);
      do_trig(t);
      wait_idle(100, "single_idle");
      chk("single_npulse", pq.size(), 1);
      if (pq.size() > 0) begin
         chk("single_pulse_cyc", pq[0], t + 5);
         chk("single_ctrl", cq[0], 16'd5);
      end
      chk("single_done_cyc", done_cyc, t + 6);
      chk("single_after_ctrl", bus.err_ctrl, 16'hFFFF);
      chk("single_inj", bus.inj_cnt, 1);

      // burst
      clear_mon();
      send_cmd(16'd9, 2'd1, 16'd4, 16'd2);
      do_trig(t);
      wait_idle(100, "burst_idle");
      chk("burst_npulse", pq.size(), 4);
      for (int i = 0; i < 4 && i < pq.size(); i++)
         chk("burst_pulse_cyc", pq[i], t + 4 + 3 * i);
      chk("burst_inj", bus.inj_cnt, 4);
      chk("burst_ndone", ndone, 1);

      // sweep wrap
      sw_exp[0] = 16'hFFFD; sw_exp[1] = 16'hFFFE; sw_exp[2] = 16'hFFFF;
      sw_exp[3] = 16'hFFFD; sw_exp[4] = 16'hFFFE;
      clear_mon();
      send_cmd(16'hFFFD, 2'd2, 16'd5, 16'd0);
      do_trig(t);
      wait_idle(100, "sweep_idle");
      chk("sweep_npulse", cq.size(), 5);
      for (int i = 0; i < 5 && i < cq.size(); i++)
         chk("sweep_ctrl", cq[i], sw_exp[i]);
      if (pq.size() > 0) chk("sweep_first_cyc", pq[0], t + 2);

      // jitter
      clear_mon();
      send_cmd(16'h0100, 2'd3, 16'd8, 16'd1);
      do_trig(t);
      wait_idle(400, "jit_idle");
      chk("jit_npulse", pq.size(), 8);
      if (pq.size() > 0)
         chk("jit_first_range", (pq[0] - t - 2 >= 1) && (pq[0] - t - 2 <= 16), 1);
      for (int i = 1; i < pq.size(); i++)
         chk("jit_low_range",
             (pq[i] - pq[i-1] - 1 >= 2) && (pq[i] - pq[i-1] - 1 <= 17), 1);
      clear_mon();
      send_cmd(16'h0200, 2'd3, 16'd0, 16'd1);
      do_trig(t);
      wait_idle(100, "jit0_idle");
      chk("jit_count0_npulse", pq.size(), 1);

      // abort during third WAIT
      clear_mon();
      send_cmd(16'h0021, 2'd1, 16'd10, 16'd3);
      do_trig(t);
      while (cyc < t + 11) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_ready", bus.cmd_ready, 1);
      chk("abort_ctrl", bus.err_ctrl, 16'hFFFF);
      chk("abort_inj", bus.inj_cnt, 2);
      repeat (40) @(negedge clk);
      chk("abort_npulse", pq.size(), 2);
      chk("abort_ndone", ndone, 0);

      // abort with cmd_valid in IDLE
      bus.cmd_valid = 1'b1;
      bus.abort = 1'b1;
      bus.cmd_id = 16'h0042;
      @(negedge clk);
      idle_inputs();
      chk("abort_idle_ready", bus.cmd_ready, 1);
      chk("abort_idle_ctrl", bus.err_ctrl, 16'hFFFF);

      // asynchronous reset mid-WAIT
      clear_mon();
      send_cmd(16'h004D, 2'd1, 16'd5, 16'd4);
      do_trig(t);
      while (cyc < t + 13) @(negedge clk);
      chk("pre_reset_inj", bus.inj_cnt, 2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_err_en", bus.err_en, 0);
      chk("arst_err_ctrl", bus.err_ctrl, 16'hFFFF);
      chk("arst_done", bus.done, 0);
      chk("arst_inj_cnt", bus.inj_cnt, 0);
      chk("arst_ready", bus.cmd_ready, 1);
      chk("arst_busy", bus.busy, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      repeat (30) begin
         bus.trig = 1'($urandom);
         @(negedge clk);
      end
      bus.trig = 1'b0;
      chk("post_reset_npulse", pq.size(), 0);

      // randomized commands
      for (int n = 0; n < 30; n++) begin
         rid = 16'($urandom);
         rmode = 2'($urandom_range(0, 3));
         rcnt = 16'($urandom_range(0, 6));
         rgap = 16'($urandom_range(0, 5));
         if ($urandom_range(0, 7) == 0) rgap = 16'($urandom_range(6, 30));
         send_cmd(rid, rmode, rcnt, rgap);
         repeat ($urandom_range(0, 3)) begin
            bus.cmd_valid = 1'($urandom);
            @(negedge clk);
         end
         bus.cmd_valid = 1'b0;
         if ($urandom_range(0, 7) == 0) begin
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            chk("rand_armed_abort", bus.cmd_ready, 1);
         end else begin
            bus.trig = 1'b1;
            @(negedge clk);
            k = 0;
            while (!bus.cmd_ready && k < 1500) begin
               bus.trig = 1'($urandom);
               bus.cmd_valid = 1'($urandom);
               bus.cmd_id = 16'($urandom);
               bus.abort = ($urandom_range(0, 79) == 0);
               @(negedge clk);
               k++;
            end
            idle_inputs();
            chk("rand_finish", bus.cmd_ready, 1);
         end
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
